// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words over a req/ack handshake,
// buffers DEPTH of them with their addresses, and handles flush/redirect and HALT.
module instr_fetch_queue #(
    parameter int         DEPTH   = 4,
    parameter int         AW      = 8,
    parameter logic [4:0] NOP_OP  = 5'b00000,
    parameter logic [4:0] HALT_OP = 5'b00001
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          flush,
    input  logic [AW-1:0] flush_addr,
    output logic          m_req,
    output logic [AW-1:0] m_addr,
    input  logic          m_ack,
    input  logic [15:0]   m_rdata,
    output logic          i_valid,
    output logic [15:0]   i_data,
    output logic [AW-1:0] i_pc,
    input  logic          i_ready,
    output logic          halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_m_req;
    logic [AW-1:0]   r_m_addr;
    logic [AW-1:0]   r_fptr;
    logic            r_discard;
    logic [15:0]     r_data [DEPTH];
    logic [AW-1:0]   r_pc   [DEPTH];
    logic [PW-1:0]   r_wp, r_rp;
    logic [CW-1:0]   r_cnt;

    logic            w_ack, w_flush, w_redir, w_push, w_pop;
    logic            w_pend_nxt, w_discard_nxt, w_issue;
    logic [AW-1:0]   w_raddr, w_fptr_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_ack       = m_ack & r_m_req;
        w_flush     = flush & (r_state != S_IDLE);
        w_redir     = w_flush | start;
        w_raddr     = w_flush ? flush_addr : start_addr;
        // A redirect swallows any ack landing in the same cycle.
        w_push      = w_ack & ~r_discard & ~w_redir;
        w_pop       = i_valid & i_ready & enable & ~w_redir;
        w_pend_nxt  = r_m_req & ~m_ack;
        // At most one ack is ever discarded: the one for the request already in flight.
        w_discard_nxt = w_pend_nxt & (r_discard | w_redir);
        w_cnt_nxt   = w_redir ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
        w_fptr_nxt  = w_redir ? w_raddr : (w_push ? r_m_addr + 1'b1 : r_fptr);
        w_state_nxt = r_state;
        if (w_redir)
            w_state_nxt = S_FETCH;
        else if (w_push && m_rdata[15:11] == HALT_OP)
            w_state_nxt = S_HALTED;
        // Issuing only when the post-update queue has room reserves a slot for the ack.
        w_issue = enable & ~w_pend_nxt & (w_state_nxt == S_FETCH) & (w_cnt_nxt < DEPTH_C);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_m_req   <= 1'b0;
            r_m_addr  <= '0;
            r_fptr    <= '0;
            r_discard <= 1'b0;
            r_cnt     <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
        end else begin
            r_m_req   <= w_pend_nxt | w_issue;
            if (w_issue) r_m_addr <= w_fptr_nxt;
            r_fptr    <= w_fptr_nxt;
            r_discard <= w_discard_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_redir) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + 1'b1;
                if (w_pop)  r_rp <= r_rp + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data[r_wp] <= m_rdata;
            r_pc[r_wp]   <= r_m_addr;
        end
    end

    assign m_req   = r_m_req;
    assign m_addr  = r_m_addr;
    assign i_valid = (r_cnt != '0);
    assign i_data  = i_valid ? r_data[r_rp] : {NOP_OP, 11'b0};
    assign i_pc    = i_valid ? r_pc[r_rp] : '0;
    assign halted  = (r_state == S_HALTED) & ~i_valid;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: table of per-cycle vectors plus
// hand-written flush, halt and reset sequences against a wait-state memory model.
module tb_instr_fetch_queue;
    logic        clock = 1'b0;
    logic        reset = 1'b1, enable = 1'b1, start = 1'b0, flush = 1'b0;
    logic        i_ready = 1'b0, force_ack = 1'b0, halt_en = 1'b0;
    logic [7:0]  start_addr = '0, flush_addr = '0;
    logic        m_req, m_ack, i_valid, halted;
    logic [7:0]  m_addr, i_pc;
    logic [15:0] m_rdata, i_data;
    int          wait_cyc = 0, cnt = 0;
    int          n_tests = 0, n_fail = 0;

    instr_fetch_queue dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .start_addr(start_addr), .flush(flush), .flush_addr(flush_addr),
        .m_req(m_req), .m_addr(m_addr), .m_ack(m_ack), .m_rdata(m_rdata),
        .i_valid(i_valid), .i_data(i_data), .i_pc(i_pc), .i_ready(i_ready),
        .halted(halted)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] mem_word(input logic [7:0] a, input logic he);
        if (he && a == 8'h05) return {5'b00001, 3'b000, a};
        return {5'b00000, 3'b000, a};
    endfunction

    // Memory acks after wait_cyc cycles of m_req being high.
    assign m_rdata = mem_word(m_addr, halt_en);
    assign m_ack   = (m_req && cnt == wait_cyc) || force_ack;
    always @(posedge clock)
        if (reset || !m_req || m_ack) cnt <= 0;
        else                          cnt <= cnt + 1;

    typedef struct {
        logic       rst, st;
        logic [7:0] sa;
        logic       en, rdy;
        logic       ev;
        logic [7:0] epc;
        logic       emreq;
        logic [7:0] emaddr;
        logic       ehalt;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic rst, st, input logic [7:0] sa, input logic en, rdy,
                                input logic ev, input logic [7:0] epc, input logic emreq,
                                input logic [7:0] emaddr, input logic ehalt);
        vec_t v;
        v.rst = rst; v.st = st; v.sa = sa; v.en = en; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.emreq = emreq; v.emaddr = emaddr; v.ehalt = ehalt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; force_ack = 1'b0;
        enable = 1'b1; halt_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic flush_seq(input logic dbl);
        logic       found, saw13, got;
        logic [7:0] first;
        do_reset();
        wait_cyc = 3; i_ready = 1'b1;
        start = 1'b1; start_addr = 8'h10;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_req && m_addr == 8'h13) found = 1'b1;
            else tick();
        end
        chk("flush_reach13", 64'(found), 64'(1'b1));
        flush = 1'b1; flush_addr = 8'h40;
        tick();
        flush = 1'b0;
        chk("flush_pending13", {i_valid, m_req, m_addr}, {1'b0, 1'b1, 8'h13});
        if (dbl) begin
            flush = 1'b1; flush_addr = 8'h60;
            tick();
            flush = 1'b0;
            chk("flush2_pending13", {i_valid, m_req, m_addr}, {1'b0, 1'b1, 8'h13});
        end
        saw13 = 1'b0; got = 1'b0; first = 8'h00;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (i_valid) begin
                if (i_pc == 8'h13) saw13 = 1'b1;
                first = i_pc;
                got = 1'b1;
            end
        end
        chk("flush_no13", 64'(saw13), 64'(1'b0));
        chk("flush_first_pc", 64'(first), dbl ? 64'h60 : 64'h40);
    endtask

    task automatic halt_seq();
        logic [23:0] seqv;
        int          npops;
        logic        saw06;
        do_reset();
        wait_cyc = 0; halt_en = 1'b1; i_ready = 1'b1;
        start = 1'b1; start_addr = 8'h03;
        tick();
        start = 1'b0;
        seqv = '0; npops = 0; saw06 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_req && m_addr == 8'h06) saw06 = 1'b1;
            if (i_valid) begin
                seqv = {seqv[15:0], i_pc};
                npops++;
            end
            tick();
        end
        chk("halt_seq", {8'(npops), seqv}, {8'd3, 24'h030405});
        chk("halt_no06", 64'(saw06), 64'(1'b0));
        chk("halted", {halted, m_req}, {1'b1, 1'b0});
        start = 1'b1; start_addr = 8'h20;
        tick();
        start = 1'b0;
        chk("restart_req", {halted, m_req, m_addr}, {1'b0, 1'b1, 8'h20});
        tick();
        chk("restart_pc", {i_valid, i_pc}, {1'b1, 8'h20});
        halt_en = 1'b0;
    endtask

    task automatic reset_seq();
        logic found;
        do_reset();
        wait_cyc = 3; i_ready = 1'b0;
        start = 1'b1; start_addr = 8'h10;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_req && m_addr == 8'h12) found = 1'b1;
            else tick();
        end
        chk("rst_reach12", 64'(found), 64'(1'b1));
        chk("rst_head", {i_valid, i_pc}, {1'b1, 8'h10});
        reset = 1'b1;
        tick();
        chk("rst_outputs", {m_req, m_addr, i_valid, i_data, i_pc, halted}, 64'h0);
        reset = 1'b0; force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        chk("late_ack_ignored", {m_req, i_valid}, 2'b00);
        tick();
        chk("idle_stays", {m_req, i_valid, halted}, 3'b000);
    endtask

    initial begin
        // Zero-wait streaming from 8'h10
        add(1,0,8'h00,1,1, 0,8'h00,0,8'h00,0);
        add(0,1,8'h10,1,1, 0,8'h00,1,8'h10,0);
        add(0,0,8'h00,1,1, 1,8'h10,1,8'h11,0);
        add(0,0,8'h00,1,1, 1,8'h11,1,8'h12,0);
        add(0,0,8'h00,1,1, 1,8'h12,1,8'h13,0);
        add(0,0,8'h00,1,1, 1,8'h13,1,8'h14,0);
        // Backpressure: queue fills to 4 and requests stop, then drains in order
        add(1,0,8'h00,1,0, 0,8'h00,0,8'h00,0);
        add(0,1,8'h10,1,0, 0,8'h00,1,8'h10,0);
        add(0,0,8'h00,1,0, 1,8'h10,1,8'h11,0);
        add(0,0,8'h00,1,0, 1,8'h10,1,8'h12,0);
        add(0,0,8'h00,1,0, 1,8'h10,1,8'h13,0);
        for (int i = 0; i < 6; i++) add(0,0,8'h00,1,0, 1,8'h10,0,8'h13,0);
        add(0,0,8'h00,1,1, 1,8'h11,1,8'h14,0);
        add(0,0,8'h00,1,1, 1,8'h12,1,8'h15,0);
        add(0,0,8'h00,1,1, 1,8'h13,1,8'h16,0);
        add(0,0,8'h00,1,1, 1,8'h14,1,8'h17,0);
        // enable=0: in-flight ack still lands (queue full), no pop, no request
        add(0,0,8'h00,0,1, 1,8'h14,0,8'h17,0);
        add(0,0,8'h00,0,1, 1,8'h14,0,8'h17,0);
        add(0,0,8'h00,1,1, 1,8'h15,1,8'h18,0);
        // Address wrap FE -> FF -> 00 -> 01
        add(1,0,8'h00,1,1, 0,8'h00,0,8'h00,0);
        add(0,1,8'hFE,1,1, 0,8'h00,1,8'hFE,0);
        add(0,0,8'h00,1,1, 1,8'hFE,1,8'hFF,0);
        add(0,0,8'h00,1,1, 1,8'hFF,1,8'h00,0);
        add(0,0,8'h00,1,1, 1,8'h00,1,8'h01,0);
        add(0,0,8'h00,1,1, 1,8'h01,1,8'h02,0);

        wait_cyc = 0;
        foreach (vecs[k]) begin
            logic [15:0] expd;
            reset = vecs[k].rst; start = vecs[k].st; start_addr = vecs[k].sa;
            enable = vecs[k].en; i_ready = vecs[k].rdy;
            tick();
            expd = vecs[k].ev ? mem_word(vecs[k].epc, 1'b0) : 16'h0000;
            chk($sformatf("vec%0d", k),
                {i_valid, i_pc, i_data, m_req, m_addr, halted},
                {vecs[k].ev, vecs[k].epc, expd, vecs[k].emreq, vecs[k].emaddr, vecs[k].ehalt});
        end
        start = 1'b0;

        flush_seq(1'b0);
        flush_seq(1'b1);
        halt_seq();
        reset_seq();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction prefetch stage sitting directly upstream of the CPU's IF stage. Fetches 16-bit instructions from instruction memory over a req/ack handshake, buffers up to DEPTH of them with their addresses, and presents them in order to the CPU's `i_datain`. Supports pipeline flush on branch redirect and stops fetching after a HALT instruction.

## Interface
- `DEPTH`, 4: queue entries (power of two, ≥2)
- `AW`, 8: instruction address width
- `NOP_OP`, 5'b00000: opcode field `[15:11]` driven when no valid instruction
- `HALT_OP`, 5'b00001: opcode field `[15:11]` that stops fetching

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  0 = no new memory requests and no pops; in-flight acks still captured
- `start`  in  1  one-cycle pulse; begin fetching at `start_addr`
- `start_addr`  in  AW  first fetch address
- `flush`  in  1  one-cycle redirect pulse
- `flush_addr`  in  AW  redirect target
- `m_req`  out  1  memory request
- `m_addr`  out  AW  memory address, stable while `m_req`=1
- `m_ack`  in  1  memory data valid; completes the request
- `m_rdata`  in  16  instruction word, valid with `m_ack`
- `i_valid`  out  1  head entry valid
- `i_data`  out  16  head instruction, to CPU `i_datain`; `{NOP_OP,11'b0}` when `i_valid`=0
- `i_pc`  out  AW  address of head instruction
- `i_ready`  in  1  CPU consumes head this cycle
- `halted`  out  1  HALT fetched, popped, and queue empty

## Operation
- States: IDLE, FETCH, HALTED. Reset → IDLE.
- IDLE: no requests. `start` → FETCH, fetch pointer = `start_addr`.
- FETCH: at most one outstanding request. New request issued when `enable`=1, no request pending, and post-update occupancy < DEPTH. `m_req`/`m_addr` are registered; `m_req` stays high until the `m_ack` cycle.
- On `m_ack` (not discarded): push `{fetch_addr, m_rdata}`; fetch pointer +1 (wraps 8'hFF → 8'h00). If `m_rdata[15:11]`==HALT_OP → HALTED; no further requests.
- Pop when `i_valid` & `i_ready` & `enable`. Push and pop in the same cycle allowed; occupancy unchanged.
- HALTED: no requests; remaining entries drain. `halted`=1 when queue empty. `start` → FETCH at `start_addr`; `flush` → FETCH at `flush_addr`.
- `flush`: queue cleared, fetch pointer = `flush_addr`, state → FETCH (from any state except IDLE). If a request is outstanding, `m_req` remains high until its `m_ack`; that data is discarded; request to `flush_addr` issues the following cycle. Second flush while discard pending: still exactly one ack discarded, latest `flush_addr` wins.
- Priority: `reset` > `flush` > `start` > push/pop. `start` in FETCH with nothing outstanding behaves as flush to `start_addr`; with request outstanding same discard rule applies.
- `m_ack` without pending request (e.g. after reset) is ignored.

## Timing
- Reset values: `m_req`=0, `m_addr`=0, `i_valid`=0, `i_data`={NOP_OP,11'b0}, `i_pc`=0, `halted`=0, queue empty, no discard pending.
- `start` at cycle T → `m_req`=1, `m_addr`=`start_addr` at T+1.
- `m_ack` at cycle A → entry visible (`i_valid`=1) at A+1 if queue was empty; next request (`m_addr`+1) at A+1 if space.
- Zero-wait memory (`m_ack` in the first cycle `m_req` is seen): sustained 1 instruction/cycle with `i_ready`=1.
- `flush` at cycle F → `i_valid`=0 at F+1; with nothing outstanding, `m_req` for `flush_addr` at F+1.
- Outputs `i_data`/`i_pc` change only on push-into-empty, pop, flush, or reset.
- Queue never overflows: request reservation guarantees a slot for every ack.

## Test plan
- Reset, `start` with `start_addr`=8'h10, zero-wait memory (mem[a]={NOP_OP,3'b0,a}), `i_ready`=1 → `i_pc` 10,11,12,… one per cycle from T+2, `i_data[7:0]`=`i_pc`.
- Same, `i_ready`=0 for 10 cycles → exactly 4 entries held, `m_req`=0, no lost/duplicated words; release → 10,11,12,13,14 in order.
- 3-cycle-wait memory, `flush` with `flush_addr`=8'h40 while request for 8'h13 pending → 8'h13 data never appears; next `i_pc`=8'h40.
- mem[8'h05] opcode HALT_OP, start at 8'h03 → no request for 8'h06 ever; `i_pc` 03,04,05 then `halted`=1; `start` at 8'h20 → `halted`=0, fetching resumes at 8'h20.
- `start_addr`=8'hFE → `i_pc` sequence FE, FF, 00, 01.
- `reset` asserted while request pending and queue holds 2 entries → all outputs reset values next cycle; late `m_ack` ignored; `enable`=0 with full queue and `i_ready`=1 → no pop until `enable`=1.
